// File: rtl/corelet_seq_pkg.sv
// rtl/corelet_seq_pkg.sv - shared state encoding and corelet instruction codes
package corelet_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_RD,
        S_W_SHIFT,
        S_W_FLUSH,
        S_X_RD,
        S_EXEC,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [1:0] INST_IDLE  = 2'b00;
    localparam logic [1:0] INST_KLOAD = 2'b01;
    localparam logic [1:0] INST_EXEC  = 2'b10;

endpackage

// File: rtl/corelet_xmem_stream.sv
// rtl/corelet_xmem_stream.sv - xmem read streamer into L0 with full-stall and landed flag
module corelet_xmem_stream #(
    parameter int aw = 11
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic [aw-1:0] base,
    input  logic [aw-1:0] count,
    input  logic          l0_full,
    output logic          cen,
    output logic [aw-1:0] addr,
    output logic          l0_wr,
    output logic          last_landed
);

    logic [aw-1:0] cnt;
    logic          issue;

    assign issue = en && (cnt < count) && !l0_full;
    assign cen   = !issue;
    assign addr  = base + cnt;

    // The write for the final read lands the cycle after it is issued; that is the exit point.
    assign last_landed = en && (cnt == count) && l0_wr;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt   <= '0;
            l0_wr <= 1'b0;
        end else begin
            l0_wr <= issue;
            if (!en || last_landed) begin
                cnt <= '0;
            end else if (issue) begin
                cnt <= cnt + aw'(1);
            end
        end
    end

endmodule

// File: rtl/corelet_seq.sv
// rtl/corelet_seq.sv - weight-stationary corelet sequencer: weight load, activation stream, psum drain
module corelet_seq
    import corelet_seq_pkg::*;
#(
    parameter int col       = 8,
    parameter int row       = 8,
    parameter int len_kij   = 9,
    parameter int len_nij   = 36,
    parameter int wgt_base  = 64,
    parameter int act_base  = 0,
    parameter int flush_cyc = row + col,
    parameter int xmem_aw   = 11,
    parameter int pmem_aw   = 11
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               xmem_cen,
    output logic [xmem_aw-1:0] xmem_addr,
    output logic               l0_wr,
    output logic               l0_rd,
    input  logic               l0_full,
    output logic [1:0]         inst,
    input  logic               ofifo_valid,
    output logic               ofifo_rd,
    output logic               pmem_cen,
    output logic               pmem_wen,
    output logic [pmem_aw-1:0] pmem_addr,
    output logic [3:0]         kij_idx
);

    state_t             state, state_next;
    logic [15:0]        cyc_cnt;
    logic [15:0]        psum_cnt;
    logic [3:0]         kij;
    logic               strm_en, strm_last;
    logic [xmem_aw-1:0] strm_base, strm_count;
    logic               drain, drain_exit;

    assign strm_en    = (state == S_W_RD) || (state == S_X_RD);
    assign strm_base  = (state == S_W_RD) ? xmem_aw'(wgt_base + int'(kij) * col) : xmem_aw'(act_base);
    assign strm_count = (state == S_W_RD) ? xmem_aw'(col) : xmem_aw'(len_nij);

    corelet_xmem_stream #(.aw(xmem_aw)) u_stream (
        .clk         (clk),
        .reset       (reset),
        .en          (strm_en),
        .base        (strm_base),
        .count       (strm_count),
        .l0_full     (l0_full),
        .cen         (xmem_cen),
        .addr        (xmem_addr),
        .l0_wr       (l0_wr),
        .last_landed (strm_last)
    );

    // Psum drain runs alongside EXEC so ofifo never backs up into the array.
    assign drain      = ofifo_valid && ((state == S_EXEC) || (state == S_DRAIN))
                        && (psum_cnt < 16'(len_nij));
    assign drain_exit = (state == S_DRAIN) && (psum_cnt == 16'(len_nij));

    assign ofifo_rd  = drain;
    assign pmem_cen  = !drain;
    assign pmem_wen  = !drain;
    assign pmem_addr = pmem_aw'(int'(kij) * len_nij + int'(psum_cnt));
    assign kij_idx   = kij;
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);

    always_comb begin
        state_next = state;
        inst       = INST_IDLE;
        l0_rd      = 1'b0;
        case (state)
            S_IDLE:    if (start) state_next = S_W_RD;
            S_W_RD:    if (strm_last) state_next = S_W_SHIFT;
            S_W_SHIFT: begin
                inst  = INST_KLOAD;
                l0_rd = 1'b1;
                if (cyc_cnt == 16'(col - 1)) state_next = S_W_FLUSH;
            end
            S_W_FLUSH: if (cyc_cnt == 16'(flush_cyc - 1)) state_next = S_X_RD;
            S_X_RD:    if (strm_last) state_next = S_EXEC;
            S_EXEC: begin
                inst  = INST_EXEC;
                l0_rd = 1'b1;
                if (cyc_cnt == 16'(len_nij - 1)) state_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (drain_exit) state_next = (kij < 4'(len_kij - 1)) ? S_W_RD : S_DONE;
            end
            S_DONE:    state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_IDLE;
            cyc_cnt  <= '0;
            psum_cnt <= '0;
            kij      <= '0;
        end else begin
            state   <= state_next;
            cyc_cnt <= (state_next != state) ? 16'd0 : cyc_cnt + 16'd1;
            if (state == S_IDLE || drain_exit) begin
                psum_cnt <= '0;
            end else if (drain) begin
                psum_cnt <= psum_cnt + 16'd1;
            end
            if (state == S_IDLE) begin
                kij <= '0;
            end else if (drain_exit && state_next == S_W_RD) begin
                kij <= kij + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_corelet_seq.sv
// tb/tb_corelet_seq.sv - directed table-driven bench for corelet_seq with default parameters
module tb_corelet_seq;

    logic        clk, reset, start, busy, done;
    logic        xmem_cen, l0_wr, l0_rd, l0_full;
    logic [10:0] xmem_addr, pmem_addr;
    logic [1:0]  inst;
    logic        ofifo_valid, ofifo_rd, pmem_cen, pmem_wen;
    logic [3:0]  kij_idx;

    corelet_seq dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .xmem_cen(xmem_cen), .xmem_addr(xmem_addr), .l0_wr(l0_wr), .l0_rd(l0_rd),
        .l0_full(l0_full), .inst(inst), .ofifo_valid(ofifo_valid), .ofifo_rd(ofifo_rd),
        .pmem_cen(pmem_cen), .pmem_wen(pmem_wen), .pmem_addr(pmem_addr), .kij_idx(kij_idx)
    );

    typedef struct {
        string name;
        bit    alt_valid;
        bit    stall;
        bit    start_mid;
        int    exp_reads;
        int    exp_pmem;
        int    exp_full;
        int    exp_first_exec;
    } scn_t;

    int errors = 0;
    int checks = 0;

    bit alt_mode = 0;
    bit stall_armed = 0;
    bit mon_en = 0;
    int stall_left = 0;

    int cyc, rd_cnt, wr_cnt, pm_cnt, kload_cnt, exec_cnt, done_cnt, full_cnt;
    int order_err, lag_err, rd_err, drain_err, stall_err, busy_err;
    int first_kload, first_act, first_exec;
    int hits [324];
    bit prev_issue;
    int mk, mr, exp_a;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // ofifo_valid pattern and one-shot L0 stall when the activation stream reaches address 10
    initial begin
        ofifo_valid = 0;
        l0_full = 0;
        forever begin
            @(posedge clk);
            #1;
            ofifo_valid = alt_mode ? !ofifo_valid : 1'b1;
            if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) l0_full = 0;
            end else if (stall_armed && busy && xmem_addr == 11'd10) begin
                l0_full = 1;
                stall_left = 5;
                stall_armed = 0;
            end
        end
    end

    // Expected read stream per kij: 8 weights at 64+8k, then activations 0..35
    always @(negedge clk) begin
        if (start && !busy) cyc = 0;
        else cyc++;
        if (mon_en) begin
            if (!xmem_cen) begin
                mk = rd_cnt / 44;
                mr = rd_cnt % 44;
                exp_a = (mr < 8) ? 64 + 8 * mk + mr : mr - 8;
                if (rd_cnt >= 396 || int'(xmem_addr) != exp_a) order_err++;
                if (mr == 8 && first_act < 0) first_act = cyc;
                rd_cnt++;
            end
            if (l0_wr) wr_cnt++;
            if (l0_wr != prev_issue) lag_err++;
            prev_issue = !xmem_cen;
            if (l0_rd != (inst == 2'b01 || inst == 2'b10) || inst == 2'b11) rd_err++;
            if (inst == 2'b01) begin
                kload_cnt++;
                if (first_kload < 0) first_kload = cyc;
            end
            if (inst == 2'b10) begin
                exec_cnt++;
                if (first_exec < 0) first_exec = cyc;
            end
            if (!pmem_wen) begin
                pm_cnt++;
                if (pmem_addr < 11'd324) hits[pmem_addr]++;
                else drain_err++;
                if (pmem_cen || !ofifo_rd || !ofifo_valid) drain_err++;
            end
            if (ofifo_rd && (pmem_wen || !ofifo_valid)) drain_err++;
            if (l0_full) begin
                full_cnt++;
                if (!xmem_cen || xmem_addr != 11'd10) stall_err++;
            end
            if (done) begin
                done_cnt++;
                if (!busy) busy_err++;
            end
        end
    end

    task automatic clear_mon();
        rd_cnt = 0; wr_cnt = 0; pm_cnt = 0; kload_cnt = 0; exec_cnt = 0; done_cnt = 0;
        full_cnt = 0; order_err = 0; lag_err = 0; rd_err = 0; drain_err = 0;
        stall_err = 0; busy_err = 0; prev_issue = 0;
        first_kload = -1; first_act = -1; first_exec = -1;
        for (int i = 0; i < 324; i++) hits[i] = 0;
    endtask

    task automatic run_scn(input scn_t s);
        int n;
        int cover_err;
        clear_mon();
        alt_mode = s.alt_valid;
        stall_armed = s.stall;
        @(posedge clk); #1;
        mon_en = 1;
        start = 1;
        @(posedge clk); #1;
        start = 0;
        check({s.name, " busy_after_start"}, int'(busy), 1);
        check({s.name, " first_addr"}, int'(xmem_addr), 64);
        if (s.start_mid) begin
            repeat (300) @(posedge clk);
            #1; start = 1;
            @(posedge clk); #1; start = 0;
        end
        n = 0;
        while (done_cnt == 0 && n < 6000) begin
            @(posedge clk);
            n++;
        end
        #1;
        check({s.name, " done_seen"}, int'(done_cnt > 0), 1);
        check({s.name, " busy_after_done"}, int'(busy), 0);
        repeat (5) @(posedge clk);
        #1;
        mon_en = 0;
        cover_err = 0;
        for (int a = 0; a < 324; a++) if (hits[a] != 1) cover_err++;
        check({s.name, " reads"}, rd_cnt, s.exp_reads);
        check({s.name, " l0_writes"}, wr_cnt, s.exp_reads);
        check({s.name, " read_order"}, order_err, 0);
        check({s.name, " l0_wr_lag"}, lag_err, 0);
        check({s.name, " l0_rd_inst"}, rd_err, 0);
        check({s.name, " kload_cycles"}, kload_cnt, 72);
        check({s.name, " exec_cycles"}, exec_cnt, 324);
        check({s.name, " pmem_writes"}, pm_cnt, s.exp_pmem);
        check({s.name, " pmem_cover"}, cover_err, 0);
        check({s.name, " drain_handshake"}, drain_err, 0);
        check({s.name, " done_pulses"}, done_cnt, 1);
        check({s.name, " done_busy"}, busy_err, 0);
        check({s.name, " full_cycles"}, full_cnt, s.exp_full);
        check({s.name, " stall_hold"}, stall_err, 0);
        check({s.name, " first_kload"}, first_kload, 10);
        check({s.name, " first_act_rd"}, first_act, 34);
        check({s.name, " first_exec"}, first_exec, s.exp_first_exec);
    endtask

    initial begin
        scn_t tbl [3];
        int n;
        tbl[0] = '{"base",      1'b0, 1'b0, 1'b0, 396, 324, 0, 71};
        tbl[1] = '{"alt_valid", 1'b1, 1'b0, 1'b1, 396, 324, 0, 71};
        tbl[2] = '{"l0_stall",  1'b0, 1'b1, 1'b0, 396, 324, 5, 76};

        reset = 0;
        start = 0;
        clear_mon();
        repeat (3) @(posedge clk);
        #1; reset = 1;
        repeat (4) @(posedge clk);

        // reset held 3 cycles mid-idle with start asserted: reset wins
        #1; reset = 0; start = 1;
        repeat (3) @(posedge clk);
        #1; reset = 1; start = 0;
        check("rst busy", int'(busy), 0);
        check("rst xmem_cen", int'(xmem_cen), 1);
        check("rst pmem_wen", int'(pmem_wen), 1);
        check("rst pmem_cen", int'(pmem_cen), 1);
        check("rst inst", int'(inst), 0);
        check("rst kij_idx", int'(kij_idx), 0);
        check("rst l0_wr_rd", int'({l0_wr, l0_rd}), 0);
        check("rst done_ofifo_rd", int'({done, ofifo_rd}), 0);
        @(posedge clk); #1;
        check("idle after reset start", int'(busy), 0);

        // abort during EXEC of kij 4
        alt_mode = 0;
        @(posedge clk); #1; start = 1;
        @(posedge clk); #1; start = 0;
        n = 0;
        while (!(kij_idx == 4'd4 && inst == 2'b10) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("abort reached kij4 exec", int'(kij_idx == 4'd4 && inst == 2'b10), 1);
        reset = 0;
        @(posedge clk); #1;
        reset = 1;
        check("abort busy", int'(busy), 0);
        check("abort inst", int'(inst), 0);
        check("abort kij_idx", int'(kij_idx), 0);
        check("abort xmem_cen", int'(xmem_cen), 1);
        check("abort pmem_wen", int'(pmem_wen), 1);
        check("abort l0_wr_ofifo_rd", int'({l0_wr, ofifo_rd}), 0);
        repeat (3) @(posedge clk);

        for (int i = 0; i < 3; i++) begin
            run_scn(tbl[i]);
            repeat (3) @(posedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
